// File: rtl/tank_color_mapper.sv
// tank_color_mapper: double-buffered tank sprites with hit-flash, priority-muxed into a 2-stage registered RGB pipeline.
module tank_color_mapper #(
  parameter int                        NUM_TANKS    = 2,
  parameter int                        CELL_LOG2    = 5,
  parameter logic [NUM_TANKS*24-1:0]   TANK_COLORS  = {24'h000055, 24'h005500},
  parameter logic [23:0]               BG_COLOR     = 24'h000000,
  parameter logic [5:0]                FLASH_FRAMES = 6'd48
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_start,
  input  logic [10*NUM_TANKS-1:0]   TankX,
  input  logic [10*NUM_TANKS-1:0]   TankY,
  input  logic [NUM_TANKS-1:0]      hit,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  output logic [7:0]                Red,
  output logic [7:0]                Green,
  output logic [7:0]                Blue,
  output logic [NUM_TANKS-1:0]      flashing
);
  logic [9:0]           shadow_x [NUM_TANKS];
  logic [9:0]           shadow_y [NUM_TANKS];
  logic [5:0]           cnt      [NUM_TANKS];
  logic [NUM_TANKS-1:0] draw;
  logic [NUM_TANKS-1:0] draw_q;
  logic                 blank_q;
  logic [23:0]          rgb;
  genvar t;
  generate
    for (t = 0; t < NUM_TANKS; t++) begin : g_tank
      always_ff @(posedge Clk) begin
        if (!Reset_n) begin
          shadow_x[t] <= 10'h3FF;
          shadow_y[t] <= 10'h3FF;
          cnt[t]      <= 6'd0;
        end else begin
          if (frame_start) begin
            shadow_x[t] <= TankX[10*t +: 10];
            shadow_y[t] <= TankY[10*t +: 10];
          end
          if (hit[t])
            cnt[t] <= FLASH_FRAMES;
          else if (frame_start && cnt[t] != 6'd0)
            cnt[t] <= cnt[t] - 6'd1;
        end
      end
      // Hidden during the counter[2]=1 half of each 8-frame flash period.
      assign draw[t] = ((shadow_x[t] >> CELL_LOG2) == (DrawX >> CELL_LOG2)) &&
                       ((shadow_y[t] >> CELL_LOG2) == (DrawY >> CELL_LOG2)) &&
                       (cnt[t] == 6'd0 || !cnt[t][2]);
      assign flashing[t] = cnt[t] != 6'd0;
    end
  endgenerate
  always_comb begin
    rgb = BG_COLOR;
    for (int i = NUM_TANKS - 1; i >= 0; i--)
      if (draw_q[i]) rgb = TANK_COLORS[24*i +: 24];
    rgb = blank_q ? 24'h000000 : rgb;
  end
  // Stage 1 resets to blank so the refill cycles after reset output black.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      draw_q              <= '0;
      blank_q             <= 1'b1;
      {Red, Green, Blue}  <= 24'h000000;
    end else begin
      draw_q              <= draw;
      blank_q             <= blank;
      {Red, Green, Blue}  <= rgb;
    end
  end
endmodule

// File: tb/tb_tank_color_mapper.sv
// tb_tank_color_mapper: directed and random stimulus checked every cycle against a behavioural model.
module tb_tank_color_mapper;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [19:0] TankX = '0;
  logic [19:0] TankY = '0;
  logic [1:0]  hit = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b1;
  logic [7:0]  Red, Green, Blue;
  logic [1:0]  flashing;
  int total = 0;
  int fails = 0;
  tank_color_mapper #(
    .NUM_TANKS(2), .CELL_LOG2(5), .TANK_COLORS({24'h000055, 24'h005500}),
    .BG_COLOR(24'h000000), .FLASH_FRAMES(6'd48)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .TankX(TankX), .TankY(TankY),
    .hit(hit), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .Red(Red), .Green(Green), .Blue(Blue), .flashing(flashing)
  );
  always #5 Clk = ~Clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  int          sx [2];
  int          sy [2];
  int          cnt [2];
  logic [23:0] pend, exp_rgb;
  bit          mv = 0;
  function automatic logic [23:0] model_pixel(int x, int y, bit b);
    if (b) return 24'h000000;
    for (int i = 0; i < 2; i++)
      if (sx[i] / 32 == x / 32 && sy[i] / 32 == y / 32 && (cnt[i] == 0 || (cnt[i] / 4) % 2 == 0))
        return i == 0 ? 24'h005500 : 24'h000055;
    return 24'h000000;
  endfunction
  always @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) begin
        sx[i] = 1023; sy[i] = 1023; cnt[i] = 0;
      end
      pend = 0; exp_rgb = 0; mv = 1;
    end else begin
      exp_rgb = pend;
      pend = model_pixel(DrawX, DrawY, blank);
      for (int i = 0; i < 2; i++) begin
        if (hit[i]) cnt[i] = 48;
        else if (frame_start && cnt[i] > 0) cnt[i] = cnt[i] - 1;
        if (frame_start) begin
          sx[i] = (TankX >> (10 * i)) & 10'h3FF;
          sy[i] = (TankY >> (10 * i)) & 10'h3FF;
        end
      end
    end
  end
  always @(negedge Clk) if (mv) begin
    chk("model_rgb", {Red, Green, Blue}, exp_rgb);
    chk("model_flashing", flashing, {cnt[1] != 0, cnt[0] != 0});
  end
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge Clk); #1; end
  endtask
  task automatic frame();
    blank = 1; frame_start = 1; tick(); frame_start = 0;
  endtask
  task automatic pix(int x, int y);
    DrawX = 10'(x); DrawY = 10'(y); blank = 0; tick(2);
  endtask
  int n;
  initial begin
    tick(3);
    chk("reset_rgb", {Red, Green, Blue}, 24'h000000);
    chk("reset_flashing", flashing, 2'b00);
    Reset_n = 1;
    TankX = {10'd600, 10'd64}; TankY = {10'd400, 10'd96};
    pix(64, 96);
    chk("pre_frame_hidden", {Red, Green, Blue}, 24'h000000);
    frame();
    pix(64, 96);  chk("tank0_left",  {Red, Green, Blue}, 24'h005500);
    pix(95, 96);  chk("tank0_right", {Red, Green, Blue}, 24'h005500);
    pix(96, 96);  chk("past_right",  {Red, Green, Blue}, 24'h000000);
    pix(63, 96);  chk("before_left", {Red, Green, Blue}, 24'h000000);
    TankX = {10'd600, 10'd256};
    pix(64, 100);  chk("midframe_old_pos", {Red, Green, Blue}, 24'h005500);
    pix(256, 100); chk("midframe_new_pos", {Red, Green, Blue}, 24'h000000);
    frame();
    pix(256, 100); chk("after_frame_new", {Red, Green, Blue}, 24'h005500);
    pix(64, 100);  chk("after_frame_old", {Red, Green, Blue}, 24'h000000);
    TankX = {10'd128, 10'd128}; TankY = {10'd128, 10'd128};
    frame();
    pix(130, 130); chk("overlap_tank0", {Red, Green, Blue}, 24'h005500);
    hit = 2'b01; tick(); hit = 0;
    frame();
    pix(130, 130); chk("overlap_hidden_tank0", {Red, Green, Blue}, 24'h000055);
    blank = 1; tick(2);
    chk("blank_forces_zero", {Red, Green, Blue}, 24'h000000);
    hit = 2'b01; tick(); hit = 0;
    n = 0;
    repeat (60) begin
      if (flashing[0]) n++;
      frame();
    end
    chk("flash_frame_count", n, 48);
    blank = 1; hit = 2'b10; frame_start = 1; tick(); hit = 0; frame_start = 0;
    repeat (47) frame();
    chk("same_cycle_load_47", flashing[1], 1'b1);
    frame();
    chk("same_cycle_load_48", flashing[1], 1'b0);
    pix(130, 130); chk("pre_reset_pixel", {Red, Green, Blue}, 24'h005500);
    Reset_n = 0; tick();
    chk("midscan_reset_rgb", {Red, Green, Blue}, 24'h000000);
    Reset_n = 1; tick(2);
    chk("post_reset_no_tank", {Red, Green, Blue}, 24'h000000);
    repeat (4000) begin
      Reset_n     = $urandom_range(0, 299) != 0;
      frame_start = $urandom_range(0, 15) == 0;
      hit         = {$urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0};
      blank       = $urandom_range(0, 7) == 0;
      DrawX       = 10'($urandom_range(0, 255));
      DrawY       = 10'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) begin
        TankX = {10'($urandom_range(0, 255)), 10'($urandom_range(0, 255))};
        TankY = {10'($urandom_range(0, 255)), 10'($urandom_range(0, 255))};
      end
      tick();
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
